lfsr_rng: RTL and testbench



---
 rtl/lfsr_pkg.sv | 42 ++++
 rtl/lfsr_core.sv | 43 ++++
 rtl/lfsr_rng.sv | 87 ++++++++
 tb/tb_lfsr_rng.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, step function and maximal-length tap masks for the LFSR random source.
package lfsr_pkg;

  typedef enum logic {FILL, VALID} rng_state_e;

  // Callers zero-extend state and taps to 32 bits and truncate the result back to their width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
    return {state[30:0], ^(state & taps)};
  endfunction

  localparam logic [2:0]  TAPS_3  = 3'b110;
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [4:0]  TAPS_5  = 5'h14;
  localparam logic [5:0]  TAPS_6  = 6'h30;
  localparam logic [6:0]  TAPS_7  = 7'h60;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [8:0]  TAPS_9  = 9'h110;
  localparam logic [9:0]  TAPS_10 = 10'h240;
  localparam logic [10:0] TAPS_11 = 11'h500;
  localparam logic [11:0] TAPS_12 = 12'h829;
  localparam logic [12:0] TAPS_13 = 13'h100D;
  localparam logic [13:0] TAPS_14 = 14'h2015;
  localparam logic [14:0] TAPS_15 = 15'h6000;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [16:0] TAPS_17 = 17'h12000;
  localparam logic [17:0] TAPS_18 = 18'h20400;
  localparam logic [18:0] TAPS_19 = 19'h40023;
  localparam logic [19:0] TAPS_20 = 20'h90000;
  localparam logic [20:0] TAPS_21 = 21'h140000;
  localparam logic [21:0] TAPS_22 = 22'h300000;
  localparam logic [22:0] TAPS_23 = 23'h420000;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [24:0] TAPS_25 = 25'h1200000;
  localparam logic [25:0] TAPS_26 = 26'h2000023;
  localparam logic [26:0] TAPS_27 = 27'h4000013;
  localparam logic [27:0] TAPS_28 = 28'h9000000;
  localparam logic [28:0] TAPS_29 = 29'h14000000;
  localparam logic [29:0] TAPS_30 = 30'h20000029;
  localparam logic [30:0] TAPS_31 = 31'h48000000;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load, enable gating and zero-lockup guard.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_8),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_q,
  output logic [WIDTH-1:0] step_o
);

  logic [WIDTH-1:0] state_d;

  assign step_o = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS)));

  // A zero state would lock the register, so it is replaced by the default seed.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed_in;
    end else if (enable) begin
      state_d = step_o;
    end
    if (state_d == '0) begin
      state_d = SEED_DEFAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Back-pressured random source: LFSR core plus rejection-sampling range reduction to [0, RANGE-1].
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_8),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  parameter int               OUT_W        = 3,
  parameter int               RANGE        = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic [WIDTH-1:0] state_q
);

  localparam logic [OUT_W:0] RANGE_L = (OUT_W + 1)'(RANGE);

  logic [WIDTH-1:0] step;
  logic [OUT_W-1:0] cand;
  logic             cand_ok;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  rng_state_e       fsm_q;

  lfsr_core #(
    .WIDTH       (WIDTH),
    .TAPS        (TAPS),
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .load   (load),
    .seed_in(seed_in),
    .state_q(state_q),
    .step_o (step)
  );

  // The candidate is the low bits of the state being stepped into this cycle.
  assign cand    = OUT_W'(step);
  assign cand_ok = {1'b0, cand} < RANGE_L;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= FILL;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load) begin
      fsm_q       <= FILL;
      out_valid_q <= 1'b0;
    end else if (enable) begin
      case (fsm_q)
        FILL: begin
          if (cand_ok) begin
            out_q       <= cand;
            out_valid_q <= 1'b1;
            fsm_q       <= VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            if (cand_ok) begin
              out_q <= cand;
            end else begin
              out_valid_q <= 1'b0;
              fsm_q       <= FILL;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          fsm_q       <= FILL;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: directed scenarios plus randomized enable/ready/load against an integer model.
module tb_lfsr_rng;

  logic       clk = 1'b0;
  logic       reset, enable, load, out_ready;
  logic [7:0] seed_in;
  logic       out_valid, out_valid8;
  logic [2:0] out, out8;
  logic [7:0] state_q, state_q8;

  int vectors = 0;
  int miscompares = 0;
  int ms, mv, mo;

  always #5 clk = ~clk;

  lfsr_rng u_dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(out_valid), .out(out), .state_q(state_q)
  );

  lfsr_rng #(.RANGE(8)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(out_valid8), .out(out8), .state_q(state_q8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // x^8+x^6+x^5+x^4+1 as arithmetic: double, wrap at 256, add parity of tapped bits.
  function automatic int lfsr_step(input int s);
    return ((s * 2) % 256) + ($countones(s & 'hB8) % 2);
  endfunction

  // The offered value is replaced when absent or consumed; a rejected candidate leaves nothing offered.
  task automatic model_update();
    int n, c;
    if (reset) begin
      ms = 1; mv = 0; mo = 0;
    end else if (load) begin
      ms = (seed_in == 0) ? 1 : int'(seed_in);
      mv = 0;
    end else if (enable) begin
      n = lfsr_step(ms);
      c = n % 8;
      if (!mv || out_ready) begin
        mv = (c < 6) ? 1 : 0;
        if (c < 6) mo = c;
      end
      ms = (n == 0) ? 1 : n;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("state", state_q, ms);
    chk("valid", out_valid, mv);
    if (mv != 0) chk("out", out, mo);
    chk("in_range", (out_valid && out >= 6), 0);
  endtask

  int  exp_s [8] = '{'h02, 'h04, 'h08, 'h11, 'h23, 'h47, 'h8E, 'h1C};
  int  exp_v [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
  int  exp_o [8] = '{2, 4, 0, 1, 3, 0, 0, 4};
  bit  seen  [256];
  bit  seen8 [8];
  int  saved;

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; out_ready = 1'b1; seed_in = 8'h00;
    ms = 1; mv = 0; mo = 0;

    cycle(); cycle();
    chk("rst_state", state_q, 'h01);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);

    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("seq_state", state_q, exp_s[i]);
      chk("seq_valid", out_valid, exp_v[i]);
      if (exp_v[i] != 0) chk("seq_out", out, exp_o[i]);
    end

    reset = 1'b1; out_ready = 1'b0;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      cycle();
      chk("hold_out", out, 2);
      chk("hold_valid", out_valid, 1);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    saved = ms;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("frz_state", state_q, saved);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    load = 1'b1; seed_in = 8'h00;
    cycle();
    chk("ld0_state", state_q, 'h01);
    chk("ld0_valid", out_valid, 0);
    seed_in = 8'h08; out_ready = 1'b1;
    cycle();
    load = 1'b0;
    chk("ld8_state", state_q, 'h08);
    chk("ld8_valid", out_valid, 0);
    cycle();
    chk("ld8_out1", out, 1);
    chk("ld8_st1", state_q, 'h11);
    cycle();
    chk("ld8_out2", out, 3);
    chk("ld8_st2", state_q, 'h23);

    load = 1'b1; seed_in = 8'h01;
    cycle();
    load = 1'b0;
    seen = '{default: 1'b0};
    seen[1] = 1'b1;
    for (int i = 1; i < 255; i++) begin
      cycle();
      chk("nonzero", (state_q != 0), 1);
      chk("distinct", seen[state_q], 0);
      seen[state_q] = 1'b1;
    end
    cycle();
    chk("period", state_q, 'h01);

    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom % 4) != 0;
      out_ready = ($urandom % 2) != 0;
      load      = ($urandom % 20) == 0;
      seed_in   = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      cycle();
    end

    load = 1'b0; enable = 1'b1; out_ready = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0;
    seen8 = '{default: 1'b0};
    for (int i = 0; i < 255; i++) begin
      cycle();
      chk("r8_valid", out_valid8, 1);
      chk("r8_out", out8, ms % 8);
      chk("r8_state", state_q8, ms);
      seen8[out8] = 1'b1;
    end
    for (int v = 0; v < 8; v++) chk("r8_cover", seen8[v], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
